// File: rtl/rx_capture_packer.sv
`default_nettype none
// ============================================================================
// rx_capture_packer : captures a bounded burst of ADC words into a buffer, then
//                     streams it out as AXI_MM_WIDTH-wide DMA words with tlast.
// Revision: 1.0
// ============================================================================
module rx_capture_packer #(
    parameter int PARALLEL_SAMPLES = 16,
    parameter int SAMPLE_WIDTH     = 16,
    parameter int AXI_MM_WIDTH     = 128,
    parameter int BUFFER_DEPTH     = 256
) (
    input  logic                                   adc_clk,
    input  logic                                   adc_reset_n,
    input  logic [PARALLEL_SAMPLES*SAMPLE_WIDTH-1:0] adc_data_in_data,
    input  logic                                   adc_data_in_valid,
    output logic                                   adc_data_in_ready,
    input  logic [$clog2(BUFFER_DEPTH):0]          cfg_capture_len,
    input  logic                                   cfg_start,
    input  logic                                   cfg_stop,
    output logic [AXI_MM_WIDTH-1:0]                dma_out_data,
    output logic                                   dma_out_valid,
    output logic                                   dma_out_last,
    input  logic                                   dma_out_ready,
    output logic                                   busy,
    output logic [$clog2(BUFFER_DEPTH):0]          captured_words,
    output logic                                   capture_done
);

    localparam int c_IN_W = PARALLEL_SAMPLES * SAMPLE_WIDTH;
    localparam int c_R    = c_IN_W / AXI_MM_WIDTH;
    localparam int c_AW   = $clog2(BUFFER_DEPTH);
    localparam int c_CW   = c_AW + 1;
    localparam int c_RW   = (c_R > 1) ? $clog2(c_R) : 1;

    localparam logic [c_RW-1:0] c_SUB_LAST = c_RW'(c_R - 1);
    localparam logic [c_CW-1:0] c_DEPTH    = c_CW'(BUFFER_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_CAPTURE = 2'd1,
        S_READOUT = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [1:0]        r_rst_sync;
    logic              w_rst_n;

    logic [c_CW-1:0]   r_len;
    logic [c_CW-1:0]   r_captured;
    logic [c_IN_W-1:0] r_mem [BUFFER_DEPTH];

    logic [c_CW-1:0]   r_rd_ptr;
    logic              r_rd_vld;
    logic              r_rd_last;
    logic [c_IN_W-1:0] r_rd_data;

    logic [c_IN_W-1:0] r_out_word;
    logic              r_out_vld;
    logic              r_out_lastw;
    logic [c_RW-1:0]   r_sub;
    logic              r_done;

    logic              w_start_ok;
    logic              w_wr;
    logic [c_CW-1:0]   w_cap_inc;
    logic              w_out_hs;
    logic              w_out_final;
    logic              w_load_out;
    logic              w_rd_en;
    logic              w_done;
    logic [AXI_MM_WIDTH-1:0] w_out_slice;

    // Asynchronous assertion, synchronous release of the internal reset.
    always_ff @(posedge adc_clk or negedge adc_reset_n) begin
        if (!adc_reset_n) begin
            r_rst_sync <= 2'b00;
        end else begin
            r_rst_sync <= {r_rst_sync[0], 1'b1};
        end
    end

    assign w_rst_n = r_rst_sync[1];

    assign w_start_ok = (r_state == S_IDLE) && cfg_start &&
                        (cfg_capture_len != '0) && (cfg_capture_len <= c_DEPTH);
    assign w_wr       = (r_state == S_CAPTURE) && adc_data_in_valid;
    assign w_cap_inc  = r_captured + c_CW'(w_wr);

    // The read-data register acts as the prefetch stage; the ready chain
    // lets a new buffer read issue in the same cycle the output stage drains.
    assign w_out_hs    = r_out_vld && dma_out_ready;
    assign w_out_final = w_out_hs && (r_sub == c_SUB_LAST);
    assign w_load_out  = r_rd_vld && (!r_out_vld || w_out_final);
    assign w_rd_en     = (r_state == S_READOUT) && (r_rd_ptr != r_captured) &&
                         (!r_rd_vld || w_load_out);
    assign w_done      = w_out_hs && dma_out_last;

    always_ff @(posedge adc_clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_start_ok) begin
                    w_state_nxt = S_CAPTURE;
                end
            end
            S_CAPTURE: begin
                if ((w_wr && (w_cap_inc == r_len)) || (cfg_stop && (w_cap_inc != '0))) begin
                    w_state_nxt = S_READOUT;
                end else if (cfg_stop) begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_READOUT: begin
                if (w_done) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge adc_clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_len       <= '0;
            r_captured  <= '0;
            r_rd_ptr    <= '0;
            r_rd_vld    <= 1'b0;
            r_rd_last   <= 1'b0;
            r_out_word  <= '0;
            r_out_vld   <= 1'b0;
            r_out_lastw <= 1'b0;
            r_sub       <= '0;
            r_done      <= 1'b0;
        end else begin
            r_done <= w_done;

            if (w_start_ok) begin
                r_len      <= cfg_capture_len;
                r_captured <= '0;
                r_rd_ptr   <= '0;
                r_rd_vld   <= 1'b0;
                r_out_vld  <= 1'b0;
                r_sub      <= '0;
            end else begin
                if (w_wr) begin
                    r_captured <= w_cap_inc;
                end

                if (w_rd_en) begin
                    r_rd_ptr  <= r_rd_ptr + c_CW'(1);
                    r_rd_last <= (r_rd_ptr == (r_captured - c_CW'(1)));
                    r_rd_vld  <= 1'b1;
                end else if (w_load_out) begin
                    r_rd_vld  <= 1'b0;
                end

                if (w_load_out) begin
                    r_out_word  <= r_rd_data;
                    r_out_lastw <= r_rd_last;
                    r_out_vld   <= 1'b1;
                    r_sub       <= '0;
                end else if (w_out_final) begin
                    r_out_vld   <= 1'b0;
                    r_sub       <= '0;
                end else if (w_out_hs) begin
                    r_sub       <= r_sub + c_RW'(1);
                end
            end
        end
    end

    // Buffer storage carries no reset so it can map onto block RAM.
    always_ff @(posedge adc_clk) begin
        if (w_wr) begin
            r_mem[r_captured[c_AW-1:0]] <= adc_data_in_data;
        end
        if (w_rd_en) begin
            r_rd_data <= r_mem[r_rd_ptr[c_AW-1:0]];
        end
    end

    always_comb begin
        w_out_slice = '0;
        for (int j = 0; j < c_R; j++) begin
            if (r_sub == c_RW'(j)) begin
                w_out_slice = r_out_word[j*AXI_MM_WIDTH +: AXI_MM_WIDTH];
            end
        end
    end

    assign adc_data_in_ready = 1'b1;
    assign dma_out_data      = w_out_slice;
    assign dma_out_valid     = r_out_vld;
    assign dma_out_last      = r_out_vld && r_out_lastw && (r_sub == c_SUB_LAST);
    assign busy              = (r_state != S_IDLE);
    assign captured_words    = r_captured;
    assign capture_done      = r_done;

endmodule

`default_nettype wire
